// File: rtl/upg_boot_ctrl.sv
// upg_boot_ctrl
// Sequences UART program-upgrade sessions for the single-cycle CPU. The
// start_pg button is synchronised and debounced; a debounced press starts a
// session (LOAD) in which the UART programmer is released from reset and the
// CPU is held in reset. Programmer writes are routed to instruction ROM
// (adr[14]=0) or data memory (adr[14]=1) and counted. After upg_done the CPU is
// held for a short drain period and then released automatically. A session
// with no writes for TIMEOUT_CYCLES parks in FAULT until the next press.
//
// Ports
//   clock         upgrade-domain clock
//   rst           synchronous active-high reset
//   start_pg_i    raw asynchronous start button
//   upg_wen_i     programmer write strobe
//   upg_adr_i     programmer word address, bit 14 selects data memory
//   upg_done_i    programmer transfer complete (level)
//   upg_rst_o     programmer reset, active-high
//   cpu_rst_o     CPU hold reset, active-high (CPU reset = rst | cpu_rst_o)
//   imem_wen_o    instruction ROM upgrade write enable
//   dmem_wen_o    data memory upgrade write enable
//   imem_words_o  ROM words written this session (saturating)
//   dmem_words_o  DMEM words written this session (saturating)
//   state_o       0=RUN 1=LOAD 2=DRAIN 3=FAULT
//   timeout_o     high while in FAULT
module upg_boot_ctrl #(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int TIMEOUT_CYCLES  = 50000000,
    parameter int RELEASE_CYCLES  = 16
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        start_pg_i,
    input  logic        upg_wen_i,
    input  logic [14:0] upg_adr_i,
    input  logic        upg_done_i,
    output logic        upg_rst_o,
    output logic        cpu_rst_o,
    output logic        imem_wen_o,
    output logic        dmem_wen_o,
    output logic [14:0] imem_words_o,
    output logic [14:0] dmem_words_o,
    output logic [1:0]  state_o,
    output logic        timeout_o
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int REL_W = $clog2(RELEASE_CYCLES + 1) + 1;

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [REL_W-1:0] REL_LAST = REL_W'(RELEASE_CYCLES);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t            state;
    logic              sync_p0;
    logic              sync_p1;
    logic              db_level;
    logic [DB_W-1:0]   db_cnt;
    logic              press;
    logic              done_d;
    logic [TO_W-1:0]   idle_cnt;
    logic [REL_W-1:0]  rel_cnt;
    logic              in_load;
    logic              done_edge;
    logic              adr_unused;

    // Only the memory-select bit of the address matters here.
    assign adr_unused = ^upg_adr_i[13:0];

    function automatic logic [14:0] sat_inc(input logic [14:0] v);
        return (v == 15'h7FFF) ? v : v + 15'd1;
    endfunction

    // Synchroniser and debouncer: the level only flips after the synchronised
    // input has disagreed with it for DEBOUNCE_CYCLES consecutive samples.
    always_ff @(posedge clock) begin
        if (rst) begin
            sync_p0  <= 1'b0;
            sync_p1  <= 1'b0;
            db_level <= 1'b0;
            db_cnt   <= '0;
            press    <= 1'b0;
        end else begin
            sync_p0 <= start_pg_i;
            sync_p1 <= sync_p0;
            press   <= 1'b0;
            if (sync_p1 == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_level <= sync_p1;
                db_cnt   <= '0;
                press    <= sync_p1;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    // Write routing is combinational so the strobe reaches the memory in the
    // same cycle the programmer issues it.
    assign in_load    = (state == ST_LOAD);
    assign imem_wen_o = upg_wen_i & ~upg_adr_i[14] & in_load;
    assign dmem_wen_o = upg_wen_i &  upg_adr_i[14] & in_load;

    // done_d follows upg_done_i in every state, so a done level that is
    // already high when LOAD is entered shows no edge and is ignored.
    assign done_edge = upg_done_i & ~done_d;

    assign state_o = state;

    // Session FSM with registered outputs.
    always_ff @(posedge clock) begin
        if (rst) begin
            state        <= ST_RUN;
            upg_rst_o    <= 1'b1;
            cpu_rst_o    <= 1'b0;
            timeout_o    <= 1'b0;
            imem_words_o <= '0;
            dmem_words_o <= '0;
            idle_cnt     <= '0;
            rel_cnt      <= '0;
            done_d       <= 1'b0;
        end else begin
            done_d <= upg_done_i;
            if (imem_wen_o) imem_words_o <= sat_inc(imem_words_o);
            if (dmem_wen_o) dmem_words_o <= sat_inc(dmem_words_o);

            case (state)
                ST_RUN, ST_FAULT: begin
                    if (press) begin
                        state        <= ST_LOAD;
                        upg_rst_o    <= 1'b0;
                        cpu_rst_o    <= 1'b1;
                        timeout_o    <= 1'b0;
                        imem_words_o <= '0;
                        dmem_words_o <= '0;
                        idle_cnt     <= '0;
                    end
                end
                ST_LOAD: begin
                    // A done edge wins over a simultaneous timeout.
                    if (done_edge) begin
                        state     <= ST_DRAIN;
                        upg_rst_o <= 1'b1;
                        cpu_rst_o <= 1'b1;
                        rel_cnt   <= '0;
                    end else if (!upg_wen_i && idle_cnt == TO_LAST) begin
                        state     <= ST_FAULT;
                        upg_rst_o <= 1'b1;
                        cpu_rst_o <= 1'b1;
                        timeout_o <= 1'b1;
                    end else if (upg_wen_i) begin
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + TO_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (rel_cnt == REL_LAST) begin
                        state     <= ST_RUN;
                        upg_rst_o <= 1'b1;
                        cpu_rst_o <= 1'b0;
                    end else begin
                        rel_cnt <= rel_cnt + REL_W'(1);
                    end
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

endmodule
